// File: rtl/read_stage_elastic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : read_stage_elastic_pkg
//  Description : Shared widths, bundle types and operand-field positions for
//                the elastic read stage.
//                Contents: ADDR_WIDTH, INSN_WIDTH, InsnBundle, ReadBundle,
//                RS1_MSB/RS1_LSB, RS2_MSB/RS2_LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
package read_stage_elastic_pkg;

   localparam int ADDR_WIDTH = 30;   // word address; byte address is {addr, 2'b00}
   localparam int INSN_WIDTH = 32;

   // Bit positions of the source-register fields inside an instruction word
   localparam int RS1_MSB = 19;
   localparam int RS1_LSB = 15;
   localparam int RS2_MSB = 24;
   localparam int RS2_LSB = 20;

   // Bundle arriving from fetch
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [INSN_WIDTH-1:0] insn;
   } InsnBundle;

   // Bundle leaving toward execute, operands joined
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [INSN_WIDTH-1:0] insn;
      logic [31:0]           rs1_data;
      logic [31:0]           rs2_data;
   } ReadBundle;

endpackage : read_stage_elastic_pkg
`default_nettype wire

// File: rtl/read_stage_elastic_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : read_stage_elastic_fifo
//  Description : DEPTH-entry circular buffer with synchronous flush and an
//                occupancy count. DEPTH need not be a power of two.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                push, push_data  - write one entry
//                pop              - retire the head entry (ignored if empty)
//                flush            - sync clear of count and pointers
//                head_data        - current head entry (registered storage)
//                count            - number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
module read_stage_elastic_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   input  logic                           flush,
   output logic [WIDTH-1:0]               head_data,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   import read_stage_elastic_pkg::*;

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_pop;

   assign w_pop     = pop & (r_count != '0);
   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         // Stored data is intentionally left in place; only bookkeeping clears
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
         end
         if (push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!push && w_pop) r_count <= r_count - CW'(1);
      end
   end

`ifndef SYNTHESIS
   // The upstream credit rule must make a push into a full buffer impossible
   always @(posedge clk) begin
      if (rst_n && !flush)
         assert (!(push && !w_pop && (r_count == CW'(DEPTH))))
            else $error("elastic fifo overflow");
   end
`endif

endmodule : read_stage_elastic_fifo
`default_nettype wire

// File: rtl/read_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : read_stage_elastic
//  Description : Read stage between fetch and execute. Accepts instruction
//                bundles, issues register-file reads, joins the read data one
//                cycle later in a capture slot and buffers complete bundles in
//                an elastic FIFO. Synchronous flush kills all in-flight state.
//  Ports       : in_*          - upstream valid/ready bundle (addr, insn)
//                rf_*          - regfile read strobe, indices, returned data
//                out_*         - downstream valid/ready bundle with operands
//                flush         - branch redirect kill
//                count         - FIFO occupancy (capture slot excluded)
//  Revision    : 1.0 - initial release
// ============================================================================
module read_stage_elastic
   import read_stage_elastic_pkg::*;
#(
   parameter int ADDR_WIDTH = read_stage_elastic_pkg::ADDR_WIDTH,
   parameter int INSN_WIDTH = read_stage_elastic_pkg::INSN_WIDTH,
   parameter int XLEN       = 32,
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ADDR_WIDTH-1:0]      in_addr,
   input  logic [INSN_WIDTH-1:0]      in_insn,
   input  logic                       flush,
   output logic                       rf_rd_en,
   output logic [REG_AW-1:0]          rf_rs1,
   output logic [REG_AW-1:0]          rf_rs2,
   input  logic [XLEN-1:0]            rf_rs1_data,
   input  logic [XLEN-1:0]            rf_rs2_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [ADDR_WIDTH-1:0]      out_addr,
   output logic [INSN_WIDTH-1:0]      out_insn,
   output logic [XLEN-1:0]            out_rs1_data,
   output logic [XLEN-1:0]            out_rs2_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int BW = ADDR_WIDTH + INSN_WIDTH + 2*XLEN;

   logic                  r_live;       // holds in_ready low until the first edge after reset
   logic                  r_s1_valid;
   logic [ADDR_WIDTH-1:0] r_s1_addr;
   logic [INSN_WIDTH-1:0] r_s1_insn;

   logic [CW-1:0]         w_count;
   logic [CW:0]           w_occ;
   logic                  w_acc;
   logic                  w_push;
   logic                  w_pop;
   logic [BW-1:0]         w_push_data;
   logic [BW-1:0]         w_head;

   // Credit check counts the capture slot, so a bundle in s1 always has a
   // FIFO slot waiting; no dependence on out_ready.
   assign w_occ    = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid};
   assign in_ready = r_live & ~flush & (w_occ < (CW+1)'(DEPTH));
   assign w_acc    = in_valid & in_ready;

   assign rf_rd_en = w_acc;
   assign rf_rs1   = in_insn[RS1_MSB:RS1_LSB];
   assign rf_rs2   = in_insn[RS2_MSB:RS2_LSB];

   assign out_valid = (w_count != '0) & ~flush;
   assign w_pop     = out_valid & out_ready;
   assign w_push    = r_s1_valid & ~flush;

   assign w_push_data = {r_s1_addr, r_s1_insn, rf_rs1_data, rf_rs2_data};
   assign {out_addr, out_insn, out_rs1_data, out_rs2_data} = w_head;
   assign count = w_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live     <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s1_addr  <= '0;
         r_s1_insn  <= '0;
      end else begin
         r_live     <= 1'b1;
         r_s1_valid <= w_acc;   // w_acc is already 0 during flush
         if (w_acc) begin
            r_s1_addr <= in_addr;
            r_s1_insn <= in_insn;
         end
      end
   end

   read_stage_elastic_fifo #(
      .WIDTH (BW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .flush     (flush),
      .head_data (w_head),
      .count     (w_count)
   );

endmodule : read_stage_elastic
`default_nettype wire

// File: tb/tb_read_stage_elastic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_read_stage_elastic
//  Description : Directed self-checking bench for read_stage_elastic with a
//                DEPTH=4 instance (main) and a DEPTH=3 instance (wrap test).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_read_stage_elastic;

   localparam int LOG_LEVEL = 5;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] insn;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } exp_t;

   int checks   = 0;
   int failures = 0;
   int pops     = 0;
   int pops3    = 0;
   int accs3    = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DEPTH=4 instance signals ----------------
   logic        in_valid = 1'b0, in_ready, flush = 1'b0, rf_rd_en, out_valid, out_ready = 1'b0;
   logic [29:0] in_addr = '0, out_addr;
   logic [31:0] in_insn = '0, out_insn, out_rs1_data, out_rs2_data;
   logic [31:0] rs1d = '0, rs2d = '0;
   logic [4:0]  rf_rs1, rf_rs2;
   logic [2:0]  count;

   // ---------------- DEPTH=3 instance signals ----------------
   logic        in_valid3 = 1'b0, in_ready3, rf_rd_en3, out_valid3, out_ready3 = 1'b0;
   logic [29:0] in_addr3 = '0, out_addr3;
   logic [31:0] in_insn3 = '0, out_insn3, out_rs1_data3, out_rs2_data3;
   logic [31:0] rs1d3 = '0, rs2d3 = '0;
   logic [4:0]  rf_rs1_3, rf_rs2_3;
   logic [1:0]  count3;

   read_stage_elastic #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_insn(in_insn), .flush(flush), .rf_rd_en(rf_rd_en),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1_data(rs1d), .rf_rs2_data(rs2d),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_insn(out_insn), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .count(count)
   );

   read_stage_elastic #(.DEPTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_addr(in_addr3), .in_insn(in_insn3), .flush(1'b0), .rf_rd_en(rf_rd_en3),
      .rf_rs1(rf_rs1_3), .rf_rs2(rf_rs2_3), .rf_rs1_data(rs1d3), .rf_rs2_data(rs2d3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_addr(out_addr3),
      .out_insn(out_insn3), .out_rs1_data(out_rs1_data3), .out_rs2_data(out_rs2_data3),
      .count(count3)
   );

   // Register-file contents seen by both instances
   function automatic logic [31:0] rfval(input logic [4:0] r);
      if (r == 5'd10)      return 32'h0000_AAAA;
      else if (r == 5'd11) return 32'h0000_5555;
      else                 return 32'hC0DE_0000 | {27'd0, r};
   endfunction

   // R-type style word with chosen source registers and a tag in rd
   function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] tag);
      return {7'h00, rs2, rs1, 3'b000, tag, 7'h33};
   endfunction

   // Regfile: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (rf_rd_en)  begin rs1d  <= rfval(rf_rs1);   rs2d  <= rfval(rf_rs2);   end
      if (rf_rd_en3) begin rs1d3 <= rfval(rf_rs1_3); rs2d3 <= rfval(rf_rs2_3); end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: expected bundles are built from what was accepted
   exp_t q[$];
   exp_t q3[$];

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || flush) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            pops++;
            if (q.size() == 0) chk("pop_unexpected", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               chk("pop_addr", 64'(out_addr), 64'(e.addr));
               chk("pop_insn", 64'(out_insn), 64'(e.insn));
               chk("pop_rs1",  64'(out_rs1_data), 64'(e.rs1));
               chk("pop_rs2",  64'(out_rs2_data), 64'(e.rs2));
               if (LOG_LEVEL >= 5) $display("READ: addr=%h op=%h", {out_addr, 2'b00}, out_insn);
            end
         end
         if (in_valid && in_ready)
            q.push_back('{in_addr, in_insn, rfval(in_insn[19:15]), rfval(in_insn[24:20])});
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q3.delete();
      end else begin
         if (out_valid3 && out_ready3) begin
            pops3++;
            if (q3.size() == 0) chk("d3_pop_unexpected", 64'd1, 64'd0);
            else begin
               e = q3.pop_front();
               chk("d3_pop_addr", 64'(out_addr3), 64'(e.addr));
               chk("d3_pop_rs1",  64'(out_rs1_data3), 64'(e.rs1));
               chk("d3_pop_rs2",  64'(out_rs2_data3), 64'(e.rs2));
            end
         end
         if (in_valid3 && in_ready3) begin
            accs3++;
            q3.push_back('{in_addr3, in_insn3, rfval(in_insn3[19:15]), rfval(in_insn3[24:20])});
         end
      end
   end

   initial begin
      int p0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_in_ready",  64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count",     64'(count), 64'd0);
      chk("rst_out_addr",  64'(out_addr), 64'd0);
      chk("rst_out_insn",  64'(out_insn), 64'd0);
      chk("rst_out_rs1",   64'(out_rs1_data), 64'd0);
      chk("rst_rd_en",     64'(rf_rd_en), 64'd0);
      #20 rst_n = 1'b1;
      next_cycle();

      // ---------------- single instruction ----------------
      out_ready = 1'b1;
      next_cycle();
      in_valid = 1'b1; in_addr = 30'h100; in_insn = 32'h00B5_0533;
      #1;
      chk("t1_in_ready", 64'(in_ready), 64'd1);
      chk("t1_rd_en",    64'(rf_rd_en), 64'd1);
      chk("t1_rs1",      64'(rf_rs1), 64'd10);
      chk("t1_rs2",      64'(rf_rs2), 64'd11);
      next_cycle();
      in_valid = 1'b0;
      #1;
      chk("t1_T1_out_valid", 64'(out_valid), 64'd0);
      chk("t1_T1_count",     64'(count), 64'd0);
      next_cycle();
      chk("t1_T2_out_valid", 64'(out_valid), 64'd1);
      chk("t1_T2_addr",      64'(out_addr), 64'h100);
      chk("t1_T2_rs1",       64'(out_rs1_data), 64'hAAAA);
      chk("t1_T2_rs2",       64'(out_rs2_data), 64'h5555);
      next_cycle();
      chk("t1_T3_count",     64'(count), 64'd0);
      chk("t1_T3_out_valid", 64'(out_valid), 64'd0);

      // ---------------- streaming 8 back-to-back ----------------
      p0 = pops;
      for (int k = 0; k < 8; k++) begin
         next_cycle();
         in_valid = 1'b1; in_addr = 30'h200 + 30'(k);
         in_insn = mk(5'(k + 3), 5'(k + 9), 5'(k));
         #1;
         chk("t2_in_ready", 64'(in_ready), 64'd1);
      end
      next_cycle(); in_valid = 1'b0;
      next_cycle();
      next_cycle();
      chk("t2_pop_total", 64'(pops - p0), 64'd8);

      // ---------------- backpressure ----------------
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         next_cycle();
         in_valid = 1'b1; in_addr = 30'h300 + 30'(k);
         in_insn = mk(5'(k + 1), 5'(k + 2), 5'(k));
         #1;
         chk("t3_in_ready", 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
      end
      next_cycle();
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk("t3_full_count",     64'(count), 64'd4);
      chk("t3_full_in_ready",  64'(in_ready), 64'd0);
      chk("t3_full_out_valid", 64'(out_valid), 64'd1);
      next_cycle();
      chk("t3_after_pop_in_ready", 64'(in_ready), 64'd1);
      chk("t3_after_pop_count",    64'(count), 64'd3);
      next_cycle(); next_cycle(); next_cycle();
      chk("t3_drained_count", 64'(count), 64'd0);

      // ---------------- flush ----------------
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         in_valid = 1'b1; in_addr = 30'h380 + 30'(k);
         in_insn = mk(5'(k + 4), 5'(k + 5), 5'(k));
      end
      next_cycle();
      flush = 1'b1; in_valid = 1'b1; in_addr = 30'h3FF; out_ready = 1'b1;
      #1;
      chk("t5_pre_count",      64'(count), 64'd2);
      chk("t5_flush_in_ready", 64'(in_ready), 64'd0);
      chk("t5_flush_rd_en",    64'(rf_rd_en), 64'd0);
      chk("t5_flush_out_valid",64'(out_valid), 64'd0);
      next_cycle();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("t5_post_count",     64'(count), 64'd0);
      chk("t5_post_out_valid", 64'(out_valid), 64'd0);
      next_cycle();
      in_valid = 1'b1; in_addr = 30'h400; in_insn = mk(5'd10, 5'd11, 5'd7);
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      chk("t5_new_out_valid", 64'(out_valid), 64'd1);
      chk("t5_new_addr",      64'(out_addr), 64'h400);
      chk("t5_new_count",     64'(count), 64'd1);
      next_cycle();
      chk("t5_alone_out_valid", 64'(out_valid), 64'd0);
      chk("t5_alone_count",     64'(count), 64'd0);

      // ---------------- async reset mid-stream ----------------
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         in_valid = 1'b1; in_addr = 30'h480 + 30'(k);
         in_insn = mk(5'(k + 6), 5'(k + 7), 5'(k));
      end
      #1;
      chk("t6_pre_out_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_count",     64'(count), 64'd0);
      chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_in_ready",  64'(in_ready), 64'd0);
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      in_valid = 1'b1; in_addr = 30'h500; in_insn = mk(5'd11, 5'd10, 5'd3);
      #1;
      chk("t6_new_in_ready", 64'(in_ready), 64'd1);
      next_cycle();
      in_valid = 1'b0;
      next_cycle();
      chk("t6_new_out_valid", 64'(out_valid), 64'd1);
      chk("t6_new_addr",      64'(out_addr), 64'h500);
      chk("t6_new_rs1",       64'(out_rs1_data), 64'h5555);
      chk("t6_new_rs2",       64'(out_rs2_data), 64'hAAAA);
      chk("t6_new_count",     64'(count), 64'd1);
      next_cycle();
      chk("t6_no_stale_valid", 64'(out_valid), 64'd0);

      // ---------------- DEPTH=3 wrap with random backpressure ----------------
      for (int k = 0; k < 10; k++) begin
         next_cycle();
         in_valid3 = 1'b1; in_addr3 = 30'h600 + 30'(k);
         in_insn3 = mk(5'(k + 1), 5'(k + 12), 5'(k));
         out_ready3 = 1'($urandom_range(0, 1));
         #1;
         chk("d3_count_le_3", 64'(count3 <= 2'd3), 64'd1);
      end
      next_cycle();
      in_valid3 = 1'b0; out_ready3 = 1'b1;
      for (int k = 0; k < 6; k++) next_cycle();
      chk("d3_drained_count", 64'(count3), 64'd0);
      chk("d3_pops_eq_accs",  64'(pops3), 64'(accs3));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_read_stage_elastic
`default_nettype wire

// File: doc/read_stage_elastic.md
Name: read_stage_elastic

Overview:
- Parametrised successor to the single-register read stage. Accepts instruction bundles under valid/ready handshake and issues register-file operand reads for rs1/rs2.
- Joins the one-cycle-late read data with its instruction and buffers complete bundles in a DEPTH-entry circular FIFO, so decode backpressure no longer drops instructions.
- Supports a synchronous flush for branch redirect. Sits between fetch and execute.

Parameters:
- ADDR_WIDTH, core::ADDR_WIDTH (30): word address width; byte address is {addr, 2'b00}.
- INSN_WIDTH, core::INSN_WIDTH (32): instruction width.
- XLEN, 32: register data width.
- REG_AW, 5: register index width.
- DEPTH, 4: FIFO entries; legal range >= 2; DEPTH >= 3 gives 1 insn/cycle sustained.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept this cycle
- in_addr  in  ADDR_WIDTH  word address of insn
- in_insn  in  INSN_WIDTH  instruction word
- flush  in  1  synchronous kill of all in-flight state
- rf_rd_en  out  1  regfile read strobe
- rf_rs1  out  REG_AW  read index 1 = in_insn[19:15]
- rf_rs2  out  REG_AW  read index 2 = in_insn[24:20]
- rf_rs1_data  in  XLEN  data for rf_rs1, valid the cycle after rf_rd_en
- rf_rs2_data  in  XLEN  data for rf_rs2, same timing
- out_valid  out  1  head bundle valid
- out_ready  in  1  downstream accepts
- out_addr  out  ADDR_WIDTH  head address
- out_insn  out  INSN_WIDTH  head instruction
- out_rs1_data  out  XLEN  head operand 1
- out_rs2_data  out  XLEN  head operand 2
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the capture slot

Behaviour:
- Reset (rst_n=0, async): s1_valid, count, and the rd/wr pointers go to 0; all FIFO storage and the capture register go to 0. All outputs are therefore 0: in_ready rises to 1 only after release, out_* are 0.
- Accept: acc = in_valid & in_ready.
  - in_ready = ~flush & ((count + s1_valid) < DEPTH). It is credit based and has no combinational path from out_ready.
  - rf_rd_en = acc. rf_rs1 and rf_rs2 are combinational decodes of in_insn, driven even when rf_rd_en=0.
- Capture slot s1: on acc at cycle T, s1 latches addr/insn and s1_valid=1 at T+1. At T+1, rf_rs*_data is joined with s1 and pushed into the FIFO at the end of T+1. s1 refills in the same cycle if acc.
- Pop: pop = out_valid & out_ready. out_valid = (count != 0) & ~flush. out_* show the head entry, registered.
- Latency: accept at T gives out_valid at T+2 when the FIFO was empty. There is no bypass.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers: wrap modulo DEPTH. DEPTH need not be a power of 2 (explicit compare-to-DEPTH-1 wrap).
- Full: count + s1_valid == DEPTH forces in_ready=0. A push from s1 is always guaranteed a slot by the credit rule, so overflow is impossible. An overflow attempt is a simulation assertion error.
- Empty: out_valid=0. out_* hold the last head storage value; downstream treats them as don't-care.
- Flush (synchronous, priority over everything):
  - in_ready and out_valid are forced to 0 in the flush cycle, so no accept and no pop occur.
  - Next cycle: s1_valid=0, count=0, pointers 0. Stored data is not cleared.
- Reset mid-stream: all in-flight bundles are lost immediately and no outputs glitch to valid.
- Logging: on each pop, MSG level 5 "READ: addr=%h op=%h" with the byte address.

Decomposition:
- core package additions:
  - ReadBundle typedef {addr, insn, rs1_data, rs2_data}.
  - Constants RS1_MSB=19, RS1_LSB=15, RS2_MSB=24, RS2_LSB=20.
  - Reuse the existing InsnBundle for the input side.
- One sub-module, elastic_fifo #(WIDTH, DEPTH): circular buffer with push/pop/flush and count, async active-low reset. read_stage_elastic adds the capture slot, credit logic and regfile port.

Test Plan:
- Reset, then a single insn addr=0x100 insn=0x00B50533 (rs1=10, rs2=11), regfile returns 0xAAAA/0x5555 at T+1, out_ready=1 → rf_rd_en@T with rf_rs1=10 and rf_rs2=11; out_valid@T+2 with out_addr=0x100 and operands 0xAAAA/0x5555; count back to 0 at T+3.
- Streaming 8 insns back-to-back, out_ready=1, DEPTH=4 → in_ready stays 1, 8 pops on consecutive cycles, in order.
- out_ready=0 while pushing → in_ready drops after 4 accepts (count=3 + s1=1). Releasing out_ready drains 4 entries in order and in_ready returns the cycle after the first pop.
- DEPTH=3, 10 push/pop cycles with random out_ready → order preserved across pointer wrap; count never exceeds 3.
- flush asserted with count=2, s1_valid=1, and in_valid=1 in the same cycle → no accept, no pop that cycle; next cycle count=0 and out_valid=0; an insn sent afterwards emerges alone.
- rst_n pulsed low asynchronously mid-stream between clock edges → count and out_valid go to 0 immediately. After release, the first new insn emerges with correct data and no stale entries.
